hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage datapath. It detects load-use hazards that operand forwarding cannot cover and inserts one bubble for each. It flushes wrong-path instructions on a taken branch, and freezes the whole pipeline while data memory is not ready. A bounded wait timer enters a sticky error state if memory never responds. It drives the PC, IF/ID, ID/EX and EX/MEM register enables that sit around the forwarding muxes.

---
 rtl/hazard_pkg.sv | 10 +
 rtl/lu_detect.sv | 20 ++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package hazard_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } ctrlState_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/lu_detect.sv
// Load-use detector: flags an ID instruction that needs the result of a load still in EX.
module lu_detect
    import hazard_pkg::*;
(
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic       idReadRs,
    input  logic       idReadRt,
    input  logic [4:0] exRegDst,
    input  logic       exMemRead,
    output logic       lu
);
    logic rsHit;
    logic rtHit;

    assign rsHit = idReadRs && (idRs == exRegDst);
    assign rtHit = idReadRt && (idRt == exRegDst);
    // r0 is hardwired, so a load "to" r0 never produces a dependency.
    assign lu    = exMemRead && (exRegDst != REG_ZERO) && (rsHit || rtHit);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, memory freeze
// with bounded wait, and saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idReadRs,
    input  logic             idReadRt,
    input  logic [4:0]       exRegDst,
    input  logic             exMemRead,
    input  logic             exBranchTaken,
    input  logic             memReq,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic             exmemWrite,
    output logic             memError,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrlState_t        state;
    ctrlState_t        nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic              lu;
    logic              flushEvt;
    logic              pcW, ifidW, ifidF, idexB, exmemW;

    lu_detect uLuDetect (
        .idRs      (idRs),
        .idRt      (idRt),
        .idReadRs  (idReadRs),
        .idReadRt  (idReadRt),
        .exRegDst  (exRegDst),
        .exMemRead (exMemRead),
        .lu        (lu)
    );

    always_comb begin
        nextState = state;
        flushEvt  = 1'b0;
        pcW       = 1'b0;
        ifidW     = 1'b0;
        ifidF     = 1'b0;
        idexB     = 1'b0;
        exmemW    = 1'b0;
        case (state)
            RUN: begin
                if (memReq && !memReady) begin
                    nextState = MEMWAIT;
                end else if (exBranchTaken) begin
                    // Branch wins over LU: the hazarding instruction is wrong-path anyway.
                    flushEvt = 1'b1;
                    pcW      = 1'b1;
                    ifidW    = 1'b1;
                    ifidF    = 1'b1;
                    idexB    = 1'b1;
                    exmemW   = 1'b1;
                end else if (lu) begin
                    idexB  = 1'b1;
                    exmemW = 1'b1;
                end else begin
                    pcW    = 1'b1;
                    ifidW  = 1'b1;
                    exmemW = 1'b1;
                end
            end
            MEMWAIT: begin
                if (memReady)                nextState = RUN;
                else if (waitCnt == WAIT_LAST) nextState = ERR;
            end
            ERR:     nextState = ERR;
            default: nextState = RUN;
        endcase
    end

    // Reset freezes every register enable, independent of state.
    assign pcWrite    = pcW    && !reset;
    assign ifidWrite  = ifidW  && !reset;
    assign ifidFlush  = ifidF  && !reset;
    assign idexBubble = idexB  && !reset;
    assign exmemWrite = exmemW && !reset;
    assign memError   = (state == ERR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            waitCnt    <= '0;
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            state <= nextState;
            if (state == RUN)
                waitCnt <= '0;
            else if (state == MEMWAIT && nextState == MEMWAIT)
                waitCnt <= waitCnt + WAIT_W'(1);
            if (!pcWrite && stallCount != '1)
                stallCount <= stallCount + CNT_W'(1);
            if (flushEvt && flushCount != '1)
                flushCount <= flushCount + CNT_W'(1);
        end
    end
endmodule
